// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern generator: pattern modes,
// bounce direction and the per-mode initial LED value.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_BIN    = 2'd0,
        MODE_ROT    = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_GRAY   = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    // One-hot modes start with bit0 lit; counting modes start dark.
    function automatic logic init_lsb(input mode_t m);
        return (m == MODE_ROT) || (m == MODE_BOUNCE);
    endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Control/status bundle between the board top-level and the LED pattern generator.
interface led_pattern_gen_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 32
);
    logic              EN;
    logic [1:0]        MODE;
    logic              STEP_LD;
    logic [STEP_W-1:0] STEP_IN;
    logic [WIDTH-1:0]  LED;
    logic              TICK;

    modport master (output EN, MODE, STEP_LD, STEP_IN, input LED, TICK);
    modport slave  (input EN, MODE, STEP_LD, STEP_IN, output LED, TICK);
endinterface

// File: rtl/led_prescaler.sv
// Programmable prescaler: counts enabled cycles and flags the cycle on
// which the pattern advances. Holds the run-time step register.
module led_prescaler #(
    parameter int                STEP_W = 32,
    parameter logic [STEP_W-1:0] STEP   = STEP_W'(10)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              STEP_LD,
    input  logic [STEP_W-1:0] STEP_IN,
    input  logic              CLR,
    output logic              TICK_PULSE
);
    logic [STEP_W-1:0] step_reg;
    logic [STEP_W-1:0] count;

    // Mode change (CLR) and reloads both pre-empt a tick due on the same edge.
    assign TICK_PULSE = EN && !CLR && !STEP_LD && (count == step_reg - STEP_W'(1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            step_reg <= STEP;
            count    <= '0;
        end else if (CLR) begin
            count    <= '0;
        end else if (STEP_LD) begin
            step_reg <= (STEP_IN == '0) ? STEP_W'(1) : STEP_IN;
            count    <= '0;
        end else if (EN) begin
            count    <= TICK_PULSE ? '0 : count + STEP_W'(1);
        end
    end
endmodule

// File: rtl/led_pattern_gen.sv
// LED bank pattern generator: binary, rotate, bounce and Gray patterns
// advanced by a programmable prescaler, with a registered update strobe.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int                WIDTH  = 8,
    parameter int                STEP_W = 32,
    parameter logic [STEP_W-1:0] STEP   = STEP_W'(10)
) (
    input logic             CLK,
    input logic             RST,
    led_pattern_gen_if.slave bus
);
    mode_t            mode_reg;
    dir_t             dir_q, dir_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic [WIDTH-1:0] bcnt_q, bcnt_d;
    logic             tick_q, tick_d;
    logic             tick_pulse;
    logic             mode_chg;

    assign mode_chg = (mode_t'(bus.MODE) != mode_reg);

    led_prescaler #(.STEP_W(STEP_W), .STEP(STEP)) u_presc (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (bus.EN),
        .STEP_LD    (bus.STEP_LD),
        .STEP_IN    (bus.STEP_IN),
        .CLR        (mode_chg),
        .TICK_PULSE (tick_pulse)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_reg <= MODE_BIN;
            dir_q    <= DIR_LEFT;
            led_q    <= '0;
            bcnt_q   <= '0;
            tick_q   <= 1'b0;
        end else begin
            if (mode_chg) mode_reg <= mode_t'(bus.MODE);
            dir_q    <= dir_d;
            led_q    <= led_d;
            bcnt_q   <= bcnt_d;
            tick_q   <= tick_d;
        end
    end

    always_comb begin
        dir_d  = dir_q;
        led_d  = led_q;
        bcnt_d = bcnt_q;
        tick_d = 1'b0;
        if (mode_chg) begin
            dir_d  = DIR_LEFT;
            bcnt_d = '0;
            led_d  = {{(WIDTH-1){1'b0}}, init_lsb(mode_t'(bus.MODE))};
        end else if (tick_pulse) begin
            tick_d = 1'b1;
            case (mode_reg)
                MODE_BIN: led_d = led_q + WIDTH'(1);
                MODE_ROT: begin
                    if (led_q == '0) led_d = WIDTH'(1);
                    else             led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
                end
                MODE_BOUNCE: begin
                    // Direction flips on arrival at an end so ends are never repeated.
                    if (led_q == '0) begin
                        led_d = WIDTH'(1);
                        dir_d = DIR_LEFT;
                    end else if (dir_q == DIR_LEFT) begin
                        led_d = led_q << 1;
                        if (led_d[WIDTH-1]) dir_d = DIR_RIGHT;
                    end else begin
                        led_d = led_q >> 1;
                        if (led_d[0]) dir_d = DIR_LEFT;
                    end
                end
                MODE_GRAY: begin
                    bcnt_d = bcnt_q + WIDTH'(1);
                    led_d  = bcnt_d ^ (bcnt_d >> 1);
                end
                default: led_d = led_q;
            endcase
        end
    end

    assign bus.LED  = led_q;
    assign bus.TICK = tick_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed plus randomized bench for led_pattern_gen against a position/index
// based reference model of the LED patterns.
module tb_led_pattern_gen;
    localparam int W      = 8;
    localparam int STEP_W = 32;
    localparam int STEPV  = 10;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    led_pattern_gen_if #(.WIDTH(W), .STEP_W(STEP_W)) bus ();

    led_pattern_gen #(.WIDTH(W), .STEP_W(STEP_W), .STEP(STEP_W'(STEPV))) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] m_led;
    logic         m_tick;
    longint       m_step, m_count;
    int           m_mode, m_pos, m_dir, m_gidx;

    function automatic logic [W-1:0] next_led(input logic [W-1:0] cur);
        logic [W-1:0] r;
        r = cur;
        case (m_mode)
            0: r = cur + 1'b1;
            1: r = (cur << 1) | (cur >> (W - 1));
            2: begin
                m_pos = m_pos + m_dir;
                if (m_pos == W - 1) m_dir = -1;
                if (m_pos == 0)     m_dir = 1;
                r = '0;
                r[m_pos] = 1'b1;
            end
            default: begin
                m_gidx = (m_gidx + 1) % (1 << W);
                r = W'(m_gidx ^ (m_gidx >> 1));
            end
        endcase
        return r;
    endfunction

    task automatic model_edge();
        if (RST) begin
            m_led = '0; m_tick = 0; m_count = 0; m_step = STEPV;
            m_mode = 0; m_pos = 0; m_dir = 1; m_gidx = 0;
        end else if (int'(bus.MODE) != m_mode) begin
            m_mode = int'(bus.MODE);
            m_count = 0; m_tick = 0; m_pos = 0; m_dir = 1; m_gidx = 0;
            m_led = (m_mode == 1 || m_mode == 2) ? W'(1) : W'(0);
        end else if (bus.STEP_LD) begin
            m_step = (bus.STEP_IN == 0) ? 1 : longint'(bus.STEP_IN);
            m_count = 0; m_tick = 0;
        end else if (bus.EN) begin
            if (m_count == m_step - 1) begin
                m_count = 0; m_tick = 1; m_led = next_led(m_led);
            end else begin
                m_count = m_count + 1; m_tick = 0;
            end
        end else begin
            m_tick = 0;
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            model_edge();
            @(negedge CLK);
            checks++;
            assert (bus.LED === m_led) else begin
                errors++;
                $error("FAIL model_led t=%0t got %h exp %h", $time, bus.LED, m_led);
            end
            checks++;
            assert (bus.TICK === m_tick) else begin
                errors++;
                $error("FAIL model_tick t=%0t got %b exp %b", $time, bus.TICK, m_tick);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [W-1:0] led_exp, input logic tick_exp);
        checks++;
        assert (bus.LED === led_exp && bus.TICK === tick_exp) else begin
            errors++;
            $error("FAIL %s got led=%h tick=%b exp led=%h tick=%b",
                   tag, bus.LED, bus.TICK, led_exp, tick_exp);
        end
    endtask

    task automatic load(input int v);
        bus.STEP_LD = 1'b1;
        bus.STEP_IN = STEP_W'(v);
        cyc(1);
        bus.STEP_LD = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        bus.EN = 1'b1; bus.MODE = 2'd0; bus.STEP_LD = 1'b0; bus.STEP_IN = '0;
        cyc(2);
        chk("reset", 8'h00, 1'b0);

        // Binary count at the reset step of 10, then full wrap at step 1
        RST = 1'b0;
        cyc(9);
        chk("bin_no_tick_before_10", 8'h00, 1'b0);
        cyc(1);
        chk("bin_first_tick", 8'h01, 1'b1);
        load(1);
        chk("bin_load_holds", 8'h01, 1'b0);
        cyc(254);
        chk("bin_all_ones", 8'hFF, 1'b1);
        cyc(1);
        chk("bin_wrap", 8'h00, 1'b1);

        // Bounce, step 0 stored as 1
        bus.MODE = 2'd2;
        cyc(1);
        chk("bounce_init", 8'h01, 1'b0);
        load(0);
        cyc(7);
        chk("bounce_top", 8'h80, 1'b1);
        cyc(1);
        chk("bounce_turn", 8'h40, 1'b1);
        cyc(6);
        chk("bounce_bottom", 8'h01, 1'b1);
        cyc(1);
        chk("bounce_turn_up", 8'h02, 1'b1);

        // Rotate wrap
        bus.MODE = 2'd1;
        cyc(1);
        chk("rot_init", 8'h01, 1'b0);
        cyc(7);
        chk("rot_msb", 8'h80, 1'b1);
        cyc(1);
        chk("rot_wrap", 8'h01, 1'b1);

        // Gray at step 2; a load on the mode-change edge is ignored
        bus.MODE = 2'd3; bus.STEP_LD = 1'b1; bus.STEP_IN = STEP_W'(5);
        cyc(1);
        bus.STEP_LD = 1'b0;
        chk("gray_init", 8'h00, 1'b0);
        load(2);
        cyc(8);
        chk("gray_4", 8'h06, 1'b1);
        cyc(16);

        // Reload on the due edge suppresses the tick
        bus.MODE = 2'd0;
        cyc(1);
        load(4);
        cyc(3);
        load(3);
        chk("ld_suppress", 8'h00, 1'b0);
        cyc(2);
        chk("ld_wait", 8'h00, 1'b0);
        cyc(1);
        chk("ld_next_tick", 8'h01, 1'b1);

        // Pause, mode change while paused, reset mid-period
        load(1);
        cyc(4);
        chk("bin_5", 8'h05, 1'b1);
        bus.EN = 1'b0;
        cyc(20);
        chk("pause_hold", 8'h05, 1'b0);
        bus.MODE = 2'd1;
        cyc(1);
        chk("mode_while_paused", 8'h01, 1'b0);
        bus.EN = 1'b1;
        load(10);
        cyc(4);
        RST = 1'b1;
        cyc(1);
        chk("mid_reset", 8'h00, 1'b0);
        RST = 1'b0; bus.MODE = 2'd0;
        cyc(9);
        chk("post_reset_wait", 8'h00, 1'b0);
        cyc(1);
        chk("post_reset_step", 8'h01, 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            RST         = ($urandom_range(0, 199) == 0);
            bus.EN      = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 39) == 0) bus.MODE = 2'($urandom_range(0, 3));
            bus.STEP_LD = ($urandom_range(0, 29) == 0);
            bus.STEP_IN = STEP_W'($urandom_range(0, 5));
            cyc(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
